spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 154 +++++++++++++++
 tb/tb_spi_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master (CPOL=0) that sends one frame of rd_addr, wr_addr and tx_data,
// each field MSB first, and captures the last DATA_WIDTH received bits into
// rx_data. SCLK half-period is CLK_DIV spi_clk_iob cycles.
// Optional build macro SPI_MASTER_LOOPBACK_EN: when defined, the receive path
// samples the master's own spi_mosi instead of spi_miso.
module spi_master #(
   parameter int DATA_WIDTH    = 32,
   parameter int RD_ADDR_WIDTH = 4,
   parameter int WR_ADDR_WIDTH = 4,
   parameter int CLK_DIV       = 2
) (
   input  logic                     spi_clk_iob,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [RD_ADDR_WIDTH-1:0] rd_addr,
   input  logic [WR_ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0]    tx_data,
   input  logic                     spi_miso,
   output logic                     busy,
   output logic                     done,
   output logic [DATA_WIDTH-1:0]    rx_data,
   output logic                     spi_sclk,
   output logic                     spi_cs_n,
   output logic                     spi_mosi
);

   localparam int FRAME_BITS = RD_ADDR_WIDTH + WR_ADDR_WIDTH + DATA_WIDTH;
   localparam int HALF_W     = $clog2(CLK_DIV + 1);
   localparam int BIT_W      = $clog2(FRAME_BITS + 1);
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);
   localparam logic [HALF_W-1:0] HALF_ONE  = HALF_W'(1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);
   localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t                  state_q;
   logic [HALF_W-1:0]       halfCnt_q;
   logic [BIT_W-1:0]        bitCnt_q;
   logic [FRAME_BITS-1:0]   frame_q;
   logic [DATA_WIDTH-1:0]   rxShift_q;
   logic [DATA_WIDTH-1:0]   rxData_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    sclk_q;
   logic                    csN_q;
   logic                    mosi_q;
   logic                    sampleBit;

`ifdef SPI_MASTER_LOOPBACK_EN
   assign sampleBit = mosi_q;
`else
   assign sampleBit = spi_miso;
`endif

   assign busy     = busy_q;
   assign done     = done_q;
   assign rx_data  = rxData_q;
   assign spi_sclk = sclk_q;
   assign spi_cs_n = csN_q;
   assign spi_mosi = mosi_q;

   // Frame sequencer: every output is a register updated alongside the state.
   always_ff @(posedge spi_clk_iob) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         halfCnt_q <= '0;
         bitCnt_q  <= '0;
         frame_q   <= '0;
         rxShift_q <= '0;
         rxData_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sclk_q    <= 1'b0;
         csN_q     <= 1'b1;
         mosi_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q   <= SETUP;
                  frame_q   <= {rd_addr, wr_addr, tx_data};
                  mosi_q    <= rd_addr[RD_ADDR_WIDTH-1];
                  csN_q     <= 1'b0;
                  busy_q    <= 1'b1;
                  halfCnt_q <= '0;
                  bitCnt_q  <= '0;
               end
            end
            SETUP: begin
               if (halfCnt_q == HALF_LAST) begin
                  state_q   <= SHIFT;
                  sclk_q    <= 1'b1;
                  halfCnt_q <= '0;
               end else begin
                  halfCnt_q <= halfCnt_q + HALF_ONE;
               end
            end
            SHIFT: begin
               if (sclk_q) begin
                  if (halfCnt_q == '0) begin
                     rxShift_q <= {rxShift_q[DATA_WIDTH-2:0], sampleBit};
                  end
                  if (halfCnt_q == HALF_LAST) begin
                     sclk_q    <= 1'b0;
                     halfCnt_q <= '0;
                     frame_q   <= {frame_q[FRAME_BITS-2:0], 1'b0};
                     mosi_q    <= frame_q[FRAME_BITS-2];
                  end else begin
                     halfCnt_q <= halfCnt_q + HALF_ONE;
                  end
               end else if (halfCnt_q == HALF_LAST) begin
                  halfCnt_q <= '0;
                  if (bitCnt_q == BIT_LAST) begin
                     state_q  <= HOLD;
                     mosi_q   <= 1'b0;
                     bitCnt_q <= '0;
                  end else begin
                     sclk_q   <= 1'b1;
                     bitCnt_q <= bitCnt_q + BIT_ONE;
                  end
               end else begin
                  halfCnt_q <= halfCnt_q + HALF_ONE;
               end
            end
            HOLD: begin
               if (halfCnt_q == HALF_LAST) begin
                  state_q   <= GAP;
                  csN_q     <= 1'b1;
                  done_q    <= 1'b1;
                  rxData_q  <= rxShift_q;
                  halfCnt_q <= '0;
               end else begin
                  halfCnt_q <= halfCnt_q + HALF_ONE;
               end
            end
            GAP: begin
               if (halfCnt_q == HALF_LAST) begin
                  state_q   <= IDLE;
                  busy_q    <= 1'b0;
                  halfCnt_q <= '0;
               end else begin
                  halfCnt_q <= halfCnt_q + HALF_ONE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: a scoreboard of expected frames (MOSI
// bits, received word) checked at each done pulse, plus reset, start-ignore,
// back-to-back and CLK_DIV=1 scenarios.
module tb_spi_master;

   localparam int NB = 40;
   localparam logic [31:0] SLAVE_WORD = 32'hDEADBEEF;

   typedef struct {
      logic [31:0] rx;
      logic [39:0] mosi;
   } exp_t;

   exp_t sbQ[$];

   logic        spi_clk_iob = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        start1 = 1'b0;
   logic [3:0]  rd_addr = '0;
   logic [3:0]  wr_addr = '0;
   logic [31:0] tx_data = '0;
   logic        spi_miso;
   logic        busy, done, spi_sclk, spi_cs_n, spi_mosi;
   logic [31:0] rx_data;
   logic        busy1, done1, sclk1, csN1, mosi1;
   logic [31:0] rx1;

   int testsRun = 0;
   int testsFailed = 0;

   // Default-parameter device, driven by the slave model below.
   spi_master dut (
      .spi_clk_iob(spi_clk_iob), .reset_n(reset_n), .start(start),
      .rd_addr(rd_addr), .wr_addr(wr_addr), .tx_data(tx_data),
      .spi_miso(spi_miso), .busy(busy), .done(done), .rx_data(rx_data),
      .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi)
   );

   // Fastest-SCLK device with MISO tied high.
   spi_master #(.CLK_DIV(1)) dut1 (
      .spi_clk_iob(spi_clk_iob), .reset_n(reset_n), .start(start1),
      .rd_addr(rd_addr), .wr_addr(wr_addr), .tx_data(tx_data),
      .spi_miso(1'b1), .busy(busy1), .done(done1), .rx_data(rx1),
      .spi_sclk(sclk1), .spi_cs_n(csN1), .spi_mosi(mosi1)
   );

   always #5 spi_clk_iob = ~spi_clk_iob;

   // Slave model and bus monitor for dut, evaluated away from the active edge.
   logic [NB-1:0] slaveShift = '0;
   logic [NB-1:0] mosiCap = '0;
   logic prevCs = 1'b1;
   logic prevSclk = 1'b0;
   int csLow = 0;
   int rises = 0;
   int doneCnt = 0;
   assign spi_miso = slaveShift[NB-1];

   always @(negedge spi_clk_iob) begin
      if (!spi_cs_n && prevCs) slaveShift = {8'h00, SLAVE_WORD};
      else if (!spi_sclk && prevSclk) slaveShift = {slaveShift[NB-2:0], 1'b0};
      if (spi_sclk && !prevSclk) begin
         rises = rises + 1;
         mosiCap = {mosiCap[NB-2:0], spi_mosi};
      end
      if (!spi_cs_n) csLow = csLow + 1;
      if (done) doneCnt = doneCnt + 1;
      prevCs = spi_cs_n;
      prevSclk = spi_sclk;
   end

   // Bus monitor for dut1: cs_n low time, SCLK rise count and rise spacing.
   int cyc1 = 0;
   int csLow1 = 0;
   int rises1 = 0;
   int lastRise1 = 0;
   int riseGap1 = 0;
   logic prevSclk1 = 1'b0;

   always @(negedge spi_clk_iob) begin
      cyc1 = cyc1 + 1;
      if (sclk1 && !prevSclk1) begin
         rises1 = rises1 + 1;
         riseGap1 = cyc1 - lastRise1;
         lastRise1 = cyc1;
      end
      if (!csN1) csLow1 = csLow1 + 1;
      prevSclk1 = sclk1;
   end

   int csBase, riseBase;

   function automatic logic [31:0] expRxFor(input logic [31:0] tx);
`ifdef SPI_MASTER_LOOPBACK_EN
      return tx;
`else
      return SLAVE_WORD;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      testsRun = testsRun + 1;
      if (actual !== expected) begin
         testsFailed = testsFailed + 1;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive one frame request at a negedge and check the first frame cycle.
   task automatic applyStimulus(input logic [3:0] rd, input logic [3:0] wr,
                                input logic [31:0] tx, input bit keepStart);
      exp_t e;
      rd_addr = rd;
      wr_addr = wr;
      tx_data = tx;
      e.rx = expRxFor(tx);
      e.mosi = {rd, wr, tx};
      sbQ.push_back(e);
      csBase = csLow;
      riseBase = rises;
      start = 1'b1;
      @(negedge spi_clk_iob);
      if (!keepStart) start = 1'b0;
      checkOutput("csFall", 64'(spi_cs_n), 64'(0));
      checkOutput("busyRise", 64'(busy), 64'(1));
      checkOutput("mosiBit0", 64'(spi_mosi), 64'(rd[3]));
   endtask

   // Wait from frame cycle 1 for done, then compare against the scoreboard.
   task automatic awaitFrame(input int pokeCycle, input int expLat);
      exp_t e;
      int lat;
      lat = 1;
      while (!done && lat < 400) begin
         @(negedge spi_clk_iob);
         lat = lat + 1;
         if (pokeCycle != 0 && lat == pokeCycle) start = 1'b1;
         else if (pokeCycle != 0 && lat == pokeCycle + 1) start = 1'b0;
      end
      checkOutput("doneSeen", 64'(done), 64'(1));
      if (sbQ.size() == 0) begin
         checkOutput("sbEmpty", 64'(0), 64'(1));
         return;
      end
      e = sbQ.pop_front();
      checkOutput("doneLatency", 64'(lat), 64'(expLat));
      checkOutput("rxData", 64'(rx_data), 64'(e.rx));
      checkOutput("mosiFrame", 64'(mosiCap), 64'(e.mosi));
      checkOutput("sclkRises", 64'(rises - riseBase), 64'(NB));
      checkOutput("csLowTime", 64'(csLow - csBase), 64'(164));
      checkOutput("csRise", 64'(spi_cs_n), 64'(1));
      @(negedge spi_clk_iob);
      checkOutput("donePulse", 64'(done), 64'(0));
      checkOutput("busyGap", 64'(busy), 64'(1));
      @(negedge spi_clk_iob);
      checkOutput("busyFall", 64'(busy), 64'(0));
   endtask

   initial begin
      int gap, base, lat;
      exp_t e;
      $display("[TB] spi_master bench starting");
      repeat (3) @(negedge spi_clk_iob);
      checkOutput("rstCs", 64'(spi_cs_n), 64'(1));
      checkOutput("rstSclk", 64'(spi_sclk), 64'(0));
      checkOutput("rstMosi", 64'(spi_mosi), 64'(0));
      checkOutput("rstBusy", 64'(busy), 64'(0));
      checkOutput("rstDone", 64'(done), 64'(0));
      checkOutput("rstRx", 64'(rx_data), 64'(0));
      reset_n = 1'b1;
      @(negedge spi_clk_iob);

      // Basic frame with the slave returning DEADBEEF.
      applyStimulus(4'h3, 4'hA, 32'h12345678, 1'b0);
      awaitFrame(0, 165);

      // start pulsed mid-frame must be ignored.
      base = doneCnt;
      applyStimulus(4'hC, 4'h5, 32'hA5A50F0F, 1'b0);
      awaitFrame(50, 165);
      repeat (20) @(negedge spi_clk_iob);
      checkOutput("ignoredStart", 64'(doneCnt - base), 64'(1));
      checkOutput("idleCs", 64'(spi_cs_n), 64'(1));

      // start held high: second frame begins right after GAP.
      applyStimulus(4'h9, 4'h6, 32'hCAFEF00D, 1'b1);
      awaitFrame(0, 165);
      e.rx = expRxFor(32'hCAFEF00D);
      e.mosi = {4'h9, 4'h6, 32'hCAFEF00D};
      sbQ.push_back(e);
      csBase = csLow;
      riseBase = rises;
      gap = 2;
      while (spi_cs_n && gap < 12) begin
         @(negedge spi_clk_iob);
         gap = gap + 1;
      end
      start = 1'b0;
      tx_data = 32'h0BADBAD0;
      checkOutput("backToBackGap", 64'(gap), 64'(3));
      awaitFrame(0, 165);

      // Reset at frame cycle 80 aborts with no done.
      rd_addr = 4'h1;
      wr_addr = 4'h2;
      tx_data = 32'h55AA55AA;
      start = 1'b1;
      @(negedge spi_clk_iob);
      start = 1'b0;
      lat = 1;
      while (lat < 80) begin
         @(negedge spi_clk_iob);
         lat = lat + 1;
      end
      base = doneCnt;
      reset_n = 1'b0;
      @(negedge spi_clk_iob);
      checkOutput("abortCs", 64'(spi_cs_n), 64'(1));
      checkOutput("abortSclk", 64'(spi_sclk), 64'(0));
      checkOutput("abortBusy", 64'(busy), 64'(0));
      checkOutput("abortRx", 64'(rx_data), 64'(0));
      reset_n = 1'b1;
      repeat (200) @(negedge spi_clk_iob);
      checkOutput("abortNoDone", 64'(doneCnt - base), 64'(0));

      // start in the first cycle after reset release is accepted.
      reset_n = 1'b0;
      @(negedge spi_clk_iob);
      reset_n = 1'b1;
      applyStimulus(4'h7, 4'hE, 32'h0F0F00FF, 1'b0);
      awaitFrame(0, 165);

      // CLK_DIV=1 device.
      rd_addr = 4'h3;
      wr_addr = 4'hA;
      tx_data = 32'hFFFFFFFF;
      csBase = csLow1;
      riseBase = rises1;
      start1 = 1'b1;
      @(negedge spi_clk_iob);
      start1 = 1'b0;
      lat = 1;
      while (!done1 && lat < 200) begin
         @(negedge spi_clk_iob);
         lat = lat + 1;
      end
      checkOutput("div1DoneSeen", 64'(done1), 64'(1));
      checkOutput("div1Latency", 64'(lat), 64'(83));
      checkOutput("div1CsLow", 64'(csLow1 - csBase), 64'(82));
      checkOutput("div1Rises", 64'(rises1 - riseBase), 64'(NB));
      checkOutput("div1Period", 64'(riseGap1), 64'(2));
      checkOutput("div1Rx", 64'(rx1), 64'(32'hFFFFFFFF));
      repeat (4) @(negedge spi_clk_iob);
      checkOutput("div1Idle", 64'(busy1), 64'(0));

      checkOutput("sbDrained", 64'(sbQ.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
